// File: rtl/l1cache_nw_wb_if.sv
// CPU-side request/response and memory-side request/fill signals of the
// L1 cache. The cache uses the slave modport; whatever drives the CPU
// requests and models memory uses the master modport.
//
// Handshakes: a request is transferred on a rising edge where valid and
// ready are both high. The sender holds valid and its payload until that
// edge. resp_valid and mem_resp_valid are single-cycle pulses with no
// back-pressure.
interface l1cache_nw_wb_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/l1cache_nw_wb.sv
// Set-associative, write-back, write-allocate (no fill on write miss) L1
// cache with CLOCK (second-chance) replacement: one hand pointer per set
// sweeps the ways, clearing ref bits until it finds a way with ref = 0.
// Invalid ways are always used first and leave the hand untouched.
module l1cache_nw_wb #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int NUM_SETS = 128,
  parameter int NUM_WAYS = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  l1cache_nw_wb_if.slave       bus,
  output logic [2:0]           dbg_state_o
);

  localparam int SET_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - SET_W - 2;
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    SCAN      = 3'd2,
    WB        = 3'd3,
    FILL_REQ  = 3'd4,
    FILL_WAIT = 3'd5,
    RESP      = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [WA_W-1:0]   waddr_q, waddr_d;   // latched word address
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAY_W-1:0]  victim_q, victim_d;

  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_hit_q, resp_hit_d;
  logic              mreq_valid_q, mreq_valid_d;
  logic              mreq_write_q, mreq_write_d;
  logic [ADDR_W-1:0] mreq_addr_q, mreq_addr_d;
  logic [DATA_W-1:0] mreq_wdata_q, mreq_wdata_d;

  // Storage: data/tag are not reset, per-way state bits and hands are.
  logic [DATA_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0] ref_q   [NUM_SETS];
  logic [WAY_W-1:0]    hand_q  [NUM_SETS];

  logic [SET_W-1:0] set_idx;
  logic [TAG_W-1:0] req_tag;
  logic [WAY_W-1:0] scan_way;
  logic             hit, inv_any;
  logic [WAY_W-1:0] hit_way, inv_way;

  // Array write controls produced by the FSM.
  logic              line_we, tag_we, meta_we, hand_we;
  logic [WAY_W-1:0]  line_way, meta_way, hand_val;
  logic [DATA_W-1:0] line_data;
  logic              meta_valid, meta_dirty, meta_ref;

  // Victim-resolution helpers.
  logic              go_alloc, go_wb;
  logic [WAY_W-1:0]  alloc_way, wb_way;

  assign set_idx  = waddr_q[SET_W-1:0];
  assign req_tag  = waddr_q[WA_W-1:SET_W];
  assign scan_way = hand_q[set_idx];

  assign bus.req_ready     = (state_q == IDLE) && !resp_valid_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_hit      = resp_hit_q;
  assign bus.mem_req_valid = mreq_valid_q;
  assign bus.mem_req_write = mreq_write_q;
  assign bus.mem_req_addr  = mreq_addr_q;
  assign bus.mem_req_wdata = mreq_wdata_q;
  assign dbg_state_o       = state_q;

  // Parallel tag compare; descending loop so the lowest invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[set_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  // Next-state, output-register and array-write decode.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    victim_d     = victim_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_hit_d   = 1'b0;
    mreq_valid_d = mreq_valid_q;
    mreq_write_d = mreq_write_q;
    mreq_addr_d  = mreq_addr_q;
    mreq_wdata_d = mreq_wdata_q;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    line_way     = '0;
    line_data    = '0;
    meta_we      = 1'b0;
    meta_way     = '0;
    meta_valid   = 1'b0;
    meta_dirty   = 1'b0;
    meta_ref     = 1'b0;
    hand_we      = 1'b0;
    hand_val     = '0;
    go_alloc     = 1'b0;
    go_wb        = 1'b0;
    alloc_way    = '0;
    wb_way       = '0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          wr_d    = bus.req_write;
          waddr_d = bus.req_addr[ADDR_W-1:2];
          wdata_d = bus.req_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          meta_we      = 1'b1;
          meta_way     = hit_way;
          meta_valid   = 1'b1;
          meta_dirty   = dirty_q[set_idx][hit_way] | wr_q;
          meta_ref     = 1'b1;
          line_we      = wr_q;
          line_way     = hit_way;
          line_data    = wdata_q;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_rdata_d = wr_q ? '0 : data_q[set_idx][hit_way];
          state_d      = IDLE;
        end else if (inv_any) begin
          victim_d  = inv_way;
          go_alloc  = 1'b1;
          alloc_way = inv_way;
        end else begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        hand_we  = 1'b1;
        hand_val = WAY_W'(scan_way + 1'b1);
        if (ref_q[set_idx][scan_way]) begin
          meta_we    = 1'b1;
          meta_way   = scan_way;
          meta_valid = 1'b1;
          meta_dirty = dirty_q[set_idx][scan_way];
          meta_ref   = 1'b0;
        end else begin
          victim_d = scan_way;
          if (dirty_q[set_idx][scan_way]) begin
            go_wb  = 1'b1;
            wb_way = scan_way;
          end else begin
            go_alloc  = 1'b1;
            alloc_way = scan_way;
          end
        end
      end
      WB: begin
        if (mreq_valid_q && bus.mem_req_ready) begin
          mreq_valid_d = 1'b0;
          go_alloc     = 1'b1;
          alloc_way    = victim_q;
        end
      end
      FILL_REQ: begin
        // Raise the fill request one cycle after entry so a preceding
        // writeback always shows a low cycle on mem_req_valid.
        if (!mreq_valid_q) begin
          mreq_valid_d = 1'b1;
          mreq_write_d = 1'b0;
          mreq_addr_d  = {waddr_q, 2'b00};
          mreq_wdata_d = '0;
        end else if (bus.mem_req_ready) begin
          mreq_valid_d = 1'b0;
          state_d      = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (bus.mem_resp_valid) begin
          line_we      = 1'b1;
          tag_we       = 1'b1;
          line_way     = victim_q;
          line_data    = bus.mem_resp_rdata;
          meta_we      = 1'b1;
          meta_way     = victim_q;
          meta_valid   = 1'b1;
          meta_dirty   = 1'b0;
          meta_ref     = 1'b1;
          resp_valid_d = 1'b1;
          resp_rdata_d = bus.mem_resp_rdata;
          state_d      = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (go_wb) begin
      mreq_valid_d = 1'b1;
      mreq_write_d = 1'b1;
      mreq_addr_d  = {tag_q[set_idx][wb_way], set_idx, 2'b00};
      mreq_wdata_d = data_q[set_idx][wb_way];
      state_d      = WB;
    end

    // Write misses allocate directly; read misses go fetch the block.
    if (go_alloc) begin
      if (wr_q) begin
        line_we      = 1'b1;
        tag_we       = 1'b1;
        line_way     = alloc_way;
        line_data    = wdata_q;
        meta_we      = 1'b1;
        meta_way     = alloc_way;
        meta_valid   = 1'b1;
        meta_dirty   = 1'b1;
        meta_ref     = 1'b1;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end else begin
        state_d = FILL_REQ;
      end
    end
  end

  // FSM state, latched request and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_hit_q   <= 1'b0;
      mreq_valid_q <= 1'b0;
      mreq_write_q <= 1'b0;
      mreq_addr_q  <= '0;
      mreq_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      victim_q     <= victim_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_hit_q   <= resp_hit_d;
      mreq_valid_q <= mreq_valid_d;
      mreq_write_q <= mreq_write_d;
      mreq_addr_q  <= mreq_addr_d;
      mreq_wdata_q <= mreq_wdata_d;
    end
  end

  // Data and tag arrays (no reset).
  always_ff @(posedge clk) begin
    if (line_we) data_q[set_idx][line_way] <= line_data;
    if (tag_we)  tag_q[set_idx][line_way]  <= req_tag;
  end

  // Valid/dirty/ref bits and per-set hands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ref_q[s]   <= '0;
        hand_q[s]  <= '0;
      end
    end else begin
      if (meta_we) begin
        valid_q[set_idx][meta_way] <= meta_valid;
        dirty_q[set_idx][meta_way] <= meta_dirty;
        ref_q[set_idx][meta_way]   <= meta_ref;
      end
      if (hand_we) hand_q[set_idx] <= hand_val;
    end
  end

endmodule

// File: tb/tb_l1cache_nw_wb.sv
// Directed bench for l1cache_nw_wb with default parameters
// (128 sets, 8 ways, set = addr[8:2], tag = addr[19:9]).
module tb_l1cache_nw_wb;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] dbg_state;
  int         total = 0;
  int         bad = 0;

  l1cache_nw_wb_if #(.ADDR_W(20), .DATA_W(32)) bus ();

  l1cache_nw_wb #(
    .ADDR_W(20), .DATA_W(32), .NUM_SETS(128), .NUM_WAYS(8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus.slave),
    .dbg_state_o(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic send_req(input logic w, input logic [19:0] a, input logic [31:0] d);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 20) begin
      step();
      n++;
    end
    chk("req_accepted", {31'b0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic wait_resp(output logic [31:0] rdata, output logic hit,
                           output int cyc, output logic saw_mem);
    cyc = 0;
    saw_mem = 1'b0;
    while (!bus.resp_valid && cyc < 40) begin
      if (bus.mem_req_valid) saw_mem = 1'b1;
      step();
      cyc++;
    end
    chk("resp_seen", {31'b0, bus.resp_valid}, 32'd1);
    rdata = bus.resp_rdata;
    hit   = bus.resp_hit;
  endtask

  task automatic wait_mem(output int cyc);
    cyc = 0;
    while (!bus.mem_req_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk("mem_req_seen", {31'b0, bus.mem_req_valid}, 32'd1);
  endtask

  task automatic serve_fill(input logic [19:0] exp_addr, input logic [31:0] fill);
    int c;
    wait_mem(c);
    chk("fill_write", {31'b0, bus.mem_req_write}, 32'd0);
    chk("fill_addr", {12'b0, bus.mem_req_addr}, {12'b0, exp_addr});
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("fill_req_drop", {31'b0, bus.mem_req_valid}, 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = fill;
    step();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
  endtask

  task automatic serve_wb(input logic [19:0] exp_addr, input logic [31:0] exp_data,
                          output int c);
    wait_mem(c);
    chk("wb_write", {31'b0, bus.mem_req_write}, 32'd1);
    chk("wb_addr", {12'b0, bus.mem_req_addr}, {12'b0, exp_addr});
    chk("wb_data", bus.mem_req_wdata, exp_data);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("wb_req_drop", {31'b0, bus.mem_req_valid}, 32'd0);
  endtask

  // Directed sequence
  initial begin
    logic [31:0] rd;
    logic        h;
    logic        m;
    int          c;
    int          n;
    logic [31:0] cap;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;

    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    step();
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_mem_req_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    chk("rst_state", {29'b0, dbg_state}, 32'd0);

    // Cold read miss, then a hit on the same address
    send_req(1'b0, 20'h00404, 32'h0);
    serve_fill(20'h00404, 32'hDEADBEEF);
    wait_resp(rd, h, c, m);
    chk("cold_rdata", rd, 32'hDEADBEEF);
    chk("cold_hit", {31'b0, h}, 32'd0);

    send_req(1'b0, 20'h00404, 32'h0);
    chk("lookup_not_ready", {31'b0, bus.req_ready}, 32'd0);
    wait_resp(rd, h, c, m);
    chk("rehit_latency", c, 32'd1);
    chk("rehit_no_mem", {31'b0, m}, 32'd0);
    chk("rehit_hit", {31'b0, h}, 32'd1);
    chk("rehit_rdata", rd, 32'hDEADBEEF);
    chk("rehit_state_idle", {29'b0, dbg_state}, 32'd0);
    chk("rehit_ready_t2", {31'b0, bus.req_ready}, 32'd0);
    step();
    chk("rehit_ready_t3", {31'b0, bus.req_ready}, 32'd1);

    // Write miss allocates without a fill; byte offset is ignored on read
    send_req(1'b1, 20'h00008, 32'h11111111);
    wait_resp(rd, h, c, m);
    chk("wmiss_latency", c, 32'd1);
    chk("wmiss_hit", {31'b0, h}, 32'd0);
    chk("wmiss_rdata", rd, 32'd0);
    chk("wmiss_no_mem", {31'b0, m}, 32'd0);
    send_req(1'b0, 20'h0000B, 32'h0);
    wait_resp(rd, h, c, m);
    chk("wrd_hit", {31'b0, h}, 32'd1);
    chk("wrd_rdata", rd, 32'h11111111);

    // Write hit updates data
    send_req(1'b1, 20'h0000A, 32'h22222222);
    wait_resp(rd, h, c, m);
    chk("whit_hit", {31'b0, h}, 32'd1);
    chk("whit_rdata", rd, 32'd0);
    send_req(1'b0, 20'h00008, 32'h0);
    wait_resp(rd, h, c, m);
    chk("whit_read", rd, 32'h22222222);

    // Fill set 0 with dirty lines tags 0..7
    for (int t = 0; t < 8; t++) begin
      send_req(1'b1, 20'(t << 9), 32'hA0000000 + 32'(t));
      wait_resp(rd, h, c, m);
      chk("set0_fill_hit", {31'b0, h}, 32'd0);
      chk("set0_fill_no_mem", {31'b0, m}, 32'd0);
    end

    // Tag 8: full sweep clearing every ref bit, wraps, evicts way 0
    send_req(1'b1, 20'h01000, 32'hB8);
    serve_wb(20'h00000, 32'hA0000000, c);
    chk("scan_full_latency", c, 32'd10);
    wait_resp(rd, h, c, m);
    chk("tag8_hit", {31'b0, h}, 32'd0);

    // Tag 9: hand now at 1 with ref 0, evicts way 1 immediately
    send_req(1'b1, 20'h01200, 32'hB9);
    serve_wb(20'h00200, 32'hA0000001, c);
    chk("scan_hand1_latency", c, 32'd2);
    wait_resp(rd, h, c, m);
    chk("tag9_hit", {31'b0, h}, 32'd0);

    send_req(1'b0, 20'h01000, 32'h0);
    wait_resp(rd, h, c, m);
    chk("tag8_rehit", {31'b0, h}, 32'd1);
    chk("tag8_rdata", rd, 32'hB8);

    // Read miss on full set: hand at 2 evicts dirty tag 2, then fills
    send_req(1'b0, 20'h00000, 32'h0);
    serve_wb(20'h00400, 32'hA0000002, c);
    chk("scan_hand2_latency", c, 32'd2);
    serve_fill(20'h00000, 32'h0BADF00D);
    wait_resp(rd, h, c, m);
    chk("rmiss_evict_rdata", rd, 32'h0BADF00D);
    chk("rmiss_evict_hit", {31'b0, h}, 32'd0);

    // Fill request stalled by memory for 5 cycles
    send_req(1'b0, 20'h03010, 32'h0);
    wait_mem(c);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, bus.mem_req_valid}, 32'd1);
      chk("stall_addr", {12'b0, bus.mem_req_addr}, 32'h00003010);
      chk("stall_write", {31'b0, bus.mem_req_write}, 32'd0);
      chk("stall_wdata", bus.mem_req_wdata, 32'd0);
      step();
    end
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("stall_drop", {31'b0, bus.mem_req_valid}, 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hCAFEF00D;
    step();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    n = 0;
    cap = '0;
    for (int i = 0; i < 6; i++) begin
      if (bus.resp_valid) begin
        n++;
        cap = bus.resp_rdata;
      end
      step();
    end
    chk("stall_one_resp", n, 32'd1);
    chk("stall_rdata", cap, 32'hCAFEF00D);

    // Reset during FILL_WAIT
    send_req(1'b0, 20'h05020, 32'h0);
    wait_mem(c);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    step();
    chk("pre_rst_fill_wait", {29'b0, dbg_state}, 32'd5);
    rstn = 1'b0;
    #1;
    chk("arst_state", {29'b0, dbg_state}, 32'd0);
    chk("arst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("arst_mem_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    chk("arst_mem_addr", {12'b0, bus.mem_req_addr}, 32'd0);
    chk("arst_mem_write", {31'b0, bus.mem_req_write}, 32'd0);
    chk("arst_resp_rdata", bus.resp_rdata, 32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    step();
    chk("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);

    // Stray fill data in IDLE is ignored
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h55555555;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.resp_valid) n++;
      step();
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = '0;
    end
    chk("stray_no_resp", n, 32'd0);
    chk("stray_state_idle", {29'b0, dbg_state}, 32'd0);

    // Same address misses again after reset
    send_req(1'b0, 20'h05020, 32'h0);
    serve_fill(20'h05020, 32'h12345678);
    wait_resp(rd, h, c, m);
    chk("post_rst_miss_hit", {31'b0, h}, 32'd0);
    chk("post_rst_rdata", rd, 32'h12345678);

    // Earlier line was wiped by reset too
    send_req(1'b0, 20'h00404, 32'h0);
    serve_fill(20'h00404, 32'h0F0F0F0F);
    wait_resp(rd, h, c, m);
    chk("post_rst_old_miss", {31'b0, h}, 32'd0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1cache_nw_wb.md
L1CACHE_NW_WB -- requirements
Module: l1cache_nw_wb

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 20, byte address width; DATA_W, default 32, word and block width; NUM_SETS, default 128, power of two; NUM_WAYS, default 8, power of two, 2..16.
REQ-002 Derived widths SHALL be: SET_W = log2(NUM_SETS); TAG_W = ADDR_W - SET_W - 2; set index = addr[SET_W+1:2]; tag = addr[ADDR_W-1:SET_W+2]; addr[1:0] ignored.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  high only in IDLE; request accepted on req_valid && req_ready.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_W  request byte address.
REQ-009 req_wdata  input  DATA_W  write data.
REQ-010 resp_valid  output  1  one-cycle pulse completing a request; no back-pressure.
REQ-011 resp_rdata  output  DATA_W  read data, valid with resp_valid on reads, 0 on writes.
REQ-012 resp_hit  output  1  1 if the request hit, valid with resp_valid.
REQ-013 mem_req_valid  output  1  memory request, held until mem_req_ready.
REQ-014 mem_req_ready  input  1  memory accepts the request.
REQ-015 mem_req_write  output  1  1 = writeback, 0 = fill read.
REQ-016 mem_req_addr  output  ADDR_W  word address, bits[1:0] = 0.
REQ-017 mem_req_wdata  output  DATA_W  writeback data.
REQ-018 mem_resp_valid  input  1  fill data present; single-cycle pulse.
REQ-019 mem_resp_rdata  input  DATA_W  fill data.

Function
REQ-020 Per block, the cache SHALL store data, tag, valid, dirty and ref bits; per set, it SHALL store a hand pointer of log2(NUM_WAYS) bits.
REQ-021 States SHALL be IDLE, LOOKUP, SCAN, WB, FILL_REQ, FILL_WAIT and RESP.
REQ-022 On acceptance in cycle T, the block SHALL latch the request and enter LOOKUP at T+1.
REQ-023 LOOKUP SHALL compare all ways in parallel; hit = valid && tag match; an invalid way SHALL never hit.
REQ-024 On a hit, resp_valid SHALL assert at T+2, IDLE SHALL be re-entered at T+2 and req_ready SHALL be high at T+3.
- Read hit: resp_rdata = stored data.
- Write hit: data <= wdata, dirty <= 1.
- Any hit: ref <= 1.
REQ-025 On a miss with any invalid way, the victim SHALL be the lowest-index invalid way, SCAN SHALL be skipped and the hand SHALL be unchanged.
REQ-026 On a miss with all ways valid, SCAN SHALL examine one way per cycle starting at hand.
- ref = 1: clear it and advance hand modulo NUM_WAYS.
- ref = 0: select that way as victim and set hand <= victim + 1 modulo NUM_WAYS.
- SCAN SHALL take at most NUM_WAYS+1 cycles.
REQ-027 If the victim is valid and dirty, WB SHALL issue mem_req_write = 1, addr = {victim tag, set, 2'b00}, wdata = victim data, and wait for mem_req_ready.
- A clean or invalid victim SHALL be dropped without any memory traffic.
REQ-028 A write miss SHALL allocate without a fill: data <= wdata, tag, valid = 1, dirty = 1, ref = 1; it SHALL then enter RESP with resp_hit = 0.
REQ-029 A read miss SHALL enter FILL_REQ and issue mem_req_write = 0 with the request word address; it SHALL then enter FILL_WAIT until mem_resp_valid.
- On fill: data <= mem_resp_rdata, valid = 1, dirty = 0, ref = 1.
- RESP: resp_rdata = fill data, resp_hit = 0.
REQ-030 mem_req_valid/addr/write/wdata SHALL remain stable while mem_req_valid && !mem_req_ready; mem_req_valid SHALL drop the cycle after acceptance.
REQ-031 mem_resp_valid outside FILL_WAIT SHALL be ignored.
REQ-032 At most one request SHALL be outstanding; req_valid outside IDLE has no effect.

Reset
REQ-033 rstn low SHALL, immediately and asynchronously, force: state IDLE; all valid, dirty and ref bits 0; all hands 0; resp_valid, resp_rdata, resp_hit, mem_req_valid, mem_req_write, mem_req_addr and mem_req_wdata 0.
- Data and tag arrays are not reset.
REQ-034 Reset mid-transaction SHALL abandon that transaction with no response, and req_ready SHALL be high on the first clock after rstn deasserts.

Verification
REQ-035 Cold read 0x00404 -> mem read addr 0x00404; return 0xDEADBEEF -> resp_rdata 0xDEADBEEF, hit 0; repeat the read -> hit 1 at T+2, no mem_req_valid.
REQ-036 Write 0x00008 = 0x11111111, then read 0x0000B -> hit 1, rdata 0x11111111; dirty set.
REQ-037 Writes to tags 0..7 in set 0 (addr = tag<<9), then a write to tag 8 -> SCAN clears all ref bits, wraps and evicts way 0; writeback addr 0x00000 with that way's data; hand = 1.
REQ-038 mem_req_ready low for 5 cycles during a fill -> mem_req_* outputs constant; a single resp_valid follows.
REQ-039 rstn pulsed low during FILL_WAIT -> outputs 0, no resp_valid; a later read of the same address misses.
REQ-040 mem_resp_valid pulsed in IDLE -> no state change, no response.
